// File: rtl/piso_fifo.sv
// Parallel-in serial-out element buffer: loads one packed word of DEPTH elements
// and drains it one element per accepted pop, element 0 first.
module piso_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  logic                        i_clear,
  input  logic                        i_wen,
  input  logic                        i_ren,
  input  logic [DEPTH*DATA_WIDTH-1:0] i_data_in,
  output logic [DATA_WIDTH-1:0]       o_data_out,
  output logic                        o_valid,
  output logic                        o_empty,
  output logic                        o_full,
  output logic [ADDR_WIDTH:0]         o_count
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_CNT  = (ADDR_WIDTH + 1)'(1);

  logic [DEPTH*DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0]       rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]         cntr_q, cntr_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        pop_s, load_s;

  // A load is also accepted on the cycle that pops the final element, so words stream back-to-back.
  always_comb begin
    pop_s  = i_ren && (cntr_q != '0);
    load_s = i_wen && ((cntr_q == '0) || ((cntr_q == ONE_CNT) && i_ren));
    word_d  = word_q;
    rptr_d  = rptr_q;
    cntr_d  = cntr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (i_clear) begin
      word_d  = '0;
      rptr_d  = '0;
      cntr_d  = '0;
      data_d  = '0;
      valid_d = 1'b0;
    end else begin
      if (load_s) begin
        word_d = i_data_in;
        rptr_d = '0;
        cntr_d = FULL_CNT;
      end else if (pop_s) begin
        rptr_d = rptr_q + 1'b1;
        cntr_d = cntr_q - ONE_CNT;
      end else begin
        rptr_d = rptr_q;
        cntr_d = cntr_q;
      end
      if (pop_s) begin
        data_d  = word_q[rptr_q*DATA_WIDTH +: DATA_WIDTH];
        valid_d = 1'b1;
      end else begin
        data_d  = data_q;
        valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any held word immediately.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      word_q  <= '0;
      rptr_q  <= '0;
      cntr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      rptr_q  <= rptr_d;
      cntr_q  <= cntr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data_out = data_q;
  assign o_valid    = valid_q;
  assign o_count    = cntr_q;
  assign o_empty    = (cntr_q == '0);
  assign o_full     = (cntr_q != '0);

endmodule

// File: tb/tb_piso_fifo.sv
// Self-checking bench for piso_fifo against a queue-based reference model.
module tb_piso_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
  localparam int WW    = DEPTH * DW;

  logic          clk = 1'b0;
  logic          nrst;
  logic          clear, wen, ren;
  logic [WW-1:0] din;
  logic [DW-1:0] dout;
  logic          valid, empty, full;
  logic [3:0]    count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data;
  logic          m_valid;

  piso_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_clear(clear), .i_wen(wen), .i_ren(ren),
    .i_data_in(din), .o_data_out(dout), .o_valid(valid), .o_empty(empty),
    .o_full(full), .o_count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [WW-1:0] ramp_word(input logic [DW-1:0] base);
    logic [WW-1:0] w;
    for (int k = 0; k < DEPTH; k++) w[k*DW +: DW] = base + DW'(k);
    return w;
  endfunction

  // Drive one cycle, advance the model, and return #1 after the edge.
  task automatic cycle(input logic c, input logic w, input logic r, input logic [WW-1:0] d);
    bit pop, load;
    clear = c; wen = w; ren = r; din = d;
    if (c) begin
      mq.delete(); m_data = '0; m_valid = 1'b0;
    end else begin
      pop  = r && (mq.size() != 0);
      load = w && ((mq.size() == 0) || (mq.size() == 1 && r));
      if (pop) begin
        m_data = mq.pop_front(); m_valid = 1'b1;
      end else m_valid = 1'b0;
      if (load) begin
        mq.delete();
        for (int k = 0; k < DEPTH; k++) mq.push_back(d[k*DW +: DW]);
      end
    end
    @(posedge clk); #1;
    clear = 1'b0; wen = 1'b0; ren = 1'b0;
  endtask

  function automatic logic [22:0] exp_vec();
    return {m_valid, m_data, 4'(mq.size()), (mq.size() == 0), (mq.size() != 0)};
  endfunction

  task automatic test_reset();
    nrst = 1'b0; clear = 1'b0; wen = 1'b0; ren = 1'b0; din = '0;
    mq.delete(); m_data = '0; m_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({valid, dout, count, empty, full} !== {1'b0, 16'h0000, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset: got v=%0b d=%h c=%0d e=%0b f=%0b, want v=0 d=0000 c=0 e=1 f=0",
               valid, dout, count, empty, full);
    end
  endtask

  task automatic test_single_drain();
    cycle(1'b0, 1'b1, 1'b0, ramp_word(16'h0100));
    checks++;
    if (count !== 4'd8) begin
      errors++; $display("FAIL drain_load_count: got %0d want 8", count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b0, 1'b1, '0);
      checks++;
      if ({valid, dout, count, empty, full} !== exp_vec() || dout !== 16'h0100 + 16'(i)) begin
        errors++;
        $display("FAIL drain_elem%0d: got %h want %h (raw d=%h)", i,
                 {valid, dout, count, empty, full}, exp_vec(), dout);
      end
    end
    cycle(1'b0, 1'b0, 1'b1, '0);
    checks++;
    if (valid !== 1'b0 || dout !== 16'h0107 || empty !== 1'b1) begin
      errors++; $display("FAIL drain_extra_pop: got v=%0b d=%h e=%0b want v=0 d=0107 e=1", valid, dout, empty);
    end
  endtask

  task automatic test_refused_load();
    logic [WW-1:0] a, b;
    a = rand_word(); b = rand_word();
    cycle(1'b0, 1'b1, 1'b0, a);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b0, b);
    checks++;
    if (count !== 4'd5) begin
      errors++; $display("FAIL refused_count: got %0d want 5", count);
    end
    for (int i = 3; i < DEPTH; i++) begin
      cycle(1'b0, 1'b0, 1'b1, '0);
      checks++;
      if (dout !== a[i*DW +: DW] || valid !== 1'b1) begin
        errors++; $display("FAIL refused_elem%0d: got %h want %h", i, dout, a[i*DW +: DW]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] a, b;
    a = rand_word(); b = rand_word();
    cycle(1'b0, 1'b1, 1'b0, a);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    checks++;
    if (count !== 4'd1) begin
      errors++; $display("FAIL b2b_pre_count: got %0d want 1", count);
    end
    cycle(1'b0, 1'b1, 1'b1, b);
    checks++;
    if ({valid, dout, count, empty} !== {1'b1, a[7*DW +: DW], 4'd8, 1'b0}) begin
      errors++; $display("FAIL b2b_last: got v=%0b d=%h c=%0d e=%0b want d=%h c=8", valid, dout, count, empty, a[7*DW +: DW]);
    end
    cycle(1'b0, 1'b0, 1'b1, '0);
    checks++;
    if ({valid, dout, count, empty} !== {1'b1, b[DW-1:0], 4'd7, 1'b0}) begin
      errors++; $display("FAIL b2b_first: got v=%0b d=%h c=%0d e=%0b want d=%h c=7", valid, dout, count, empty, b[DW-1:0]);
    end
    repeat (7) cycle(1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_clear();
    logic [WW-1:0] a, b;
    a = rand_word(); b = rand_word();
    cycle(1'b0, 1'b1, 1'b0, a);
    repeat (2) cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, 1'b1, b);
    checks++;
    if ({valid, dout, count, empty, full} !== {1'b0, 16'h0000, 4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL clear: got v=%0b d=%h c=%0d e=%0b f=%0b want all reset", valid, dout, count, empty, full);
    end
    cycle(1'b0, 1'b1, 1'b0, b);
    cycle(1'b0, 1'b0, 1'b1, '0);
    checks++;
    if (dout !== b[DW-1:0] || valid !== 1'b1) begin
      errors++; $display("FAIL clear_reload: got %h want %h", dout, b[DW-1:0]);
    end
  endtask

  task automatic test_async_reset();
    logic [WW-1:0] a, b;
    a = rand_word(); b = rand_word();
    cycle(1'b0, 1'b1, 1'b0, a);
    repeat (4) cycle(1'b0, 1'b0, 1'b1, '0);
    #1 nrst = 1'b0;
    #1;
    mq.delete(); m_data = '0; m_valid = 1'b0;
    checks++;
    if ({valid, dout, count, empty, full} !== {1'b0, 16'h0000, 4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL async_reset: got v=%0b d=%h c=%0d e=%0b f=%0b want all reset", valid, dout, count, empty, full);
    end
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    cycle(1'b0, 1'b1, 1'b0, b);
    cycle(1'b0, 1'b0, 1'b1, '0);
    checks++;
    if (dout !== b[DW-1:0] || valid !== 1'b1) begin
      errors++; $display("FAIL async_reload: got %h want %h", dout, b[DW-1:0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(99) < 3), ($urandom_range(99) < 40),
            ($urandom_range(99) < 75), rand_word());
      checks++;
      if ({valid, dout, count, empty, full} !== exp_vec()) begin
        errors++;
        $display("FAIL random_cyc%0d: got v/d/c/e/f=%h want %h", i, {valid, dout, count, empty, full}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_refused_load();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_fifo.md
# piso_fifo

Parallel-in serial-out element buffer for the input router: it accepts one packed word of DEPTH elements in a single cycle and drains it one DATA_WIDTH element per read. It feeds activation/weight elements serially to the downstream consumer and is the counterpart of the output router's serial-in parallel-out packing stage. It holds one word at a time, and a new word can be loaded in the same cycle the last element of the current word is read, so it streams back-to-back.

## Interface
- DEPTH, 8, elements per parallel word; power of two, ≥2
- DATA_WIDTH, 16, bits per element
- ADDR_WIDTH, $clog2(DEPTH), element index width
- i_clk  in  1  clock; all state updates on the rising edge
- i_nrst  in  1  reset; asynchronous, active-low
- i_clear  in  1  synchronous clear; highest priority after reset
- i_wen  in  1  load request for i_data_in
- i_ren  in  1  pop one element
- i_data_in  in  DEPTH*DATA_WIDTH  packed word; element k = bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_data_out  out  DATA_WIDTH  last popped element, registered
- o_valid  out  1  o_data_out was updated by the previous cycle's pop
- o_empty  out  1  no elements remaining (cntr == 0)
- o_full  out  1  word held (cntr != 0); a load is refused unless the load-on-last-pop rule below applies
- o_count  out  ADDR_WIDTH+1  elements remaining, 0..DEPTH

## Operation
- State: word register buf[DEPTH], read pointer rptr (ADDR_WIDTH bits), remaining count cntr (ADDR_WIDTH+1 bits), o_data_out, o_valid.
- State machine, derived from cntr:
  - EMPTY (cntr == 0) → DRAIN on an accepted load.
  - DRAIN (cntr > 0) → EMPTY when the last element is popped and no load is accepted.
  - DRAIN → DRAIN when the last pop and a load coincide.
- Load accept: i_wen && (cntr == 0 || (cntr == 1 && i_ren)). On accept:
  - buf ← i_data_in
  - rptr ← 0
  - cntr ← DEPTH
- Refused load (i_wen while cntr ≥ 2, or cntr == 1 without i_ren): ignored; buf, rptr and cntr are unchanged. No error flag.
- Pop accept: i_ren && cntr != 0. On accept:
  - o_data_out ← buf[rptr]
  - o_valid ← 1
  - rptr ← rptr + 1 (wraps at DEPTH)
  - cntr ← cntr − 1, unless a load is accepted in the same cycle
- Pop when empty: o_valid ← 0; o_data_out holds its value.
- No pop requested: o_valid ← 0; o_data_out holds its value.
- Drain order: element 0 (LSBs of i_data_in) first, element DEPTH−1 last.
- Simultaneous last pop and load: the output is the old buf[DEPTH−1]; the new word is in buf next cycle with rptr=0 and cntr=DEPTH.
- o_empty, o_full and o_count are combinational from cntr.

## Timing
- Reset (async, i_nrst low): buf=0, rptr=0, cntr=0, o_data_out=0, o_valid=0. Hence o_empty=1, o_full=0, o_count=0. Reset asserted mid-drain discards the word immediately.
- i_clear (sync): same values as reset on the next edge. It overrides a coincident i_wen and i_ren; no pop is output.
- Load-to-first-pop: a word loaded at edge N may be popped with i_ren high in cycle N+1, with data at edge N+1.
- Pop latency: 1 cycle. The element appears on o_data_out, with o_valid=1, the cycle after the edge at which i_ren was sampled.
- Throughput: DEPTH elements per DEPTH cycles with continuous i_ren and back-to-back loads, with no bubble.
- o_valid is a single-cycle pulse per accepted pop; it is never high for a pop attempted when empty.

## Test plan
- Reset then idle: release i_nrst → o_data_out=0, o_valid=0, o_empty=1, o_full=0, o_count=0.
- Single word drain: load word with element k = 16'h0100+k; hold i_ren for 8 cycles → o_data_out sequence 0x0100..0x0107, each with o_valid=1; then o_empty=1. A ninth i_ren gives o_valid=0 and o_data_out stays at 0x0107.
- Refused load: load word A; pop 3 elements; assert i_wen with word B (cntr=5) → o_count stays at 5, and the remaining pops return A[3]..A[7].
- Back-to-back: load A; pop continuously; assert i_wen with B in the cycle cntr==1 → outputs A[7] then B[0] on consecutive cycles; o_count goes 1→8→7; o_empty never asserts.
- Clear mid-drain: load A; pop 2; assert i_clear together with i_ren and i_wen → next cycle o_count=0, o_data_out=0, o_valid=0; a subsequent load of B drains from B[0].
- Async reset mid-drain: load A; pop 4; pulse i_nrst low between edges → outputs return to their reset values without a clock edge; after release a new load drains from element 0.
